// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: services aligned loads/stores from a
// word array after a fixed number of wait states, stalling the pipeline meanwhile.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        err_conflict,
    output logic        err_misaligned,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is taken only in IDLE, in the same cycle it is seen
    // (mem_stall rises combinationally); the pipeline keeps it presented while
    // mem_stall is high, and the single-cycle mem_done marks completion, during
    // which the still-presented request is ignored.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t              state, state_next;
    logic [3:0]          cnt, cnt_next;
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_idx;
    logic [31:0]         lat_wdata;

    logic [31:0]         mem_array [DEPTH];

    logic                req_conflict;
    logic                req_misaligned;
    logic                req_valid;
    logic                accept;
    logic                commit;
    logic                commit_write;
    logic [ADDR_W-1:0]   commit_idx;
    logic [31:0]         commit_wdata;
    logic                unused_addr_bits;

    assign req_conflict     = mem_memread & mem_memwrite;
    assign req_misaligned   = (mem_memread ^ mem_memwrite) & (|mem_addr[1:0]);
    assign req_valid        = (mem_memread ^ mem_memwrite) & ~(|mem_addr[1:0]);
    assign unused_addr_bits = ^mem_addr[31:ADDR_W+2];
    assign dbg_state        = state;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_stall  = 1'b0;
        mem_done   = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    mem_stall = 1'b1;
                    accept    = 1'b1;
                    if (WAIT_CYCLES == 1) begin
                        commit     = 1'b1;
                        cnt_next   = 4'd0;
                        state_next = S_RESP;
                    end else begin
                        cnt_next   = CNT_INIT;
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                cnt_next  = cnt - 4'd1;
                // The last stalled cycle is the one whose edge takes the count to zero.
                if (cnt <= 4'd1) begin
                    commit     = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                mem_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // With a single wait state the commit happens on the accept edge, straight from the inputs.
    always_comb begin
        commit_write = lat_write;
        commit_idx   = lat_idx;
        commit_wdata = lat_wdata;
        if (state == S_IDLE) begin
            commit_write = mem_memwrite;
            commit_idx   = mem_addr[ADDR_W+1:2];
            commit_wdata = mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= 4'd0;
            lat_write      <= 1'b0;
            lat_idx        <= '0;
            lat_wdata      <= 32'd0;
            mem_rdata      <= 32'd0;
            err_conflict   <= 1'b0;
            err_misaligned <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            err_conflict   <= (state == S_IDLE) & req_conflict;
            err_misaligned <= (state == S_IDLE) & req_misaligned;
            if (accept) begin
                lat_write <= mem_memwrite;
                lat_idx   <= mem_addr[ADDR_W+1:2];
                lat_wdata <= mem_wdata;
            end
            if (commit && !commit_write) begin
                mem_rdata <= mem_array[commit_idx];
            end
        end
    end

    // Array is never cleared; a reset on the commit edge drops the pending store.
    always_ff @(posedge clk) begin
        if (rst && commit && commit_write) begin
            mem_array[commit_idx] <= commit_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a transaction-timeline model predicts every output
// each cycle; directed scenarios plus randomized traffic drive the design.
module tb_dmem_responder;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH       = 1 << ADDR_W;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd  = 1'b0;
    logic        wr  = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_done;
    logic        err_conflict;
    logic        err_misaligned;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_memread    (rd),
        .mem_memwrite   (wr),
        .mem_addr       (addr),
        .mem_wdata      (wdata),
        .mem_rdata      (mem_rdata),
        .mem_stall      (mem_stall),
        .mem_done       (mem_done),
        .err_conflict   (err_conflict),
        .err_misaligned (err_misaligned),
        .dbg_state      (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline view: an accepted access at cycle T stalls T..T+W-1, commits at
    // the end of T+W-1 and reports done in T+W; only an idle responder accepts.
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_busy        = 0;
    int          m_done_cyc    = 0;
    bit          m_op_wr       = 0;
    int          m_idx         = 0;
    logic [31:0] m_data        = 32'd0;
    logic [31:0] m_rdata       = 32'd0;
    bit          m_rdata_known = 0;
    bit          m_errc        = 0;
    bit          m_errm        = 0;
    bit          started       = 0;

    always @(negedge clk) begin : compare
        bit idle;
        bit valid;
        bit busy;
        bit done;
        bit exp_stall;
        int idx;
        idle      = !m_busy;
        valid     = (rd ^ wr) && (addr[1:0] == 2'd0);
        idx       = int'(addr[ADDR_W+1:2]);
        busy      = m_busy && (cyc < m_done_cyc);
        done      = m_busy && (cyc == m_done_cyc);
        exp_stall = busy || (idle && valid);
        if (started) begin
            check1("mem_stall", 32'(mem_stall), 32'(exp_stall));
            check1("mem_done", 32'(mem_done), 32'(done));
            check1("err_conflict", 32'(err_conflict), 32'(m_errc));
            check1("err_misaligned", 32'(err_misaligned), 32'(m_errm));
            if (m_rdata_known) check1("mem_rdata", mem_rdata, m_rdata);
        end
        if (!rst) begin
            m_busy        = 0;
            m_rdata       = 32'd0;
            m_rdata_known = 1;
            m_errc        = 0;
            m_errm        = 0;
            started       = 1;
        end else begin
            m_errc = idle && rd && wr;
            m_errm = idle && (rd ^ wr) && (addr[1:0] != 2'd0);
            if (idle && valid) begin
                m_busy     = 1;
                m_done_cyc = cyc + WAIT_CYCLES;
                m_op_wr    = wr;
                m_idx      = idx;
                m_data     = wdata;
            end
            if (m_busy && cyc == m_done_cyc - 1) begin
                if (m_op_wr) begin
                    m_mem[m_idx]   = m_data;
                    m_known[m_idx] = 1;
                end else begin
                    m_rdata       = m_mem[m_idx];
                    m_rdata_known = m_known[m_idx];
                end
            end else if (m_busy && cyc == m_done_cyc) begin
                m_busy = 0;
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
    endtask

    // Pipeline-style access: request held until mem_done, then withdrawn.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got);
        bit seen;
        seen = 0;
        got  = 32'd0;
        set_req(r, w, a, d);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_done) begin
                seen = 1;
                got  = mem_rdata;
            end
        end
        check1("access_done_seen", 32'(seen), 32'd1);
        step();
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic pulse_req(input logic r, input logic w, input logic [31:0] a, input int n);
        set_req(r, w, a, 32'hFFFF_FFFF);
        repeat (n) step();
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] got;
        int          r;
        int          idx;
        logic [31:0] a;

        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check1("reset_rdata", mem_rdata, 32'd0);
        check1("reset_stall", 32'(mem_stall), 32'd0);
        step();

        access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, got);
        access(1'b1, 1'b0, 32'h40, 32'd0, got);
        check1("read_0x40", got, 32'hDEAD_BEEF);

        access(1'b0, 1'b1, 32'h80, 32'h1111_2222, got);
        pulse_req(1'b1, 1'b1, 32'h80, 1);
        @(negedge clk);
        check1("conflict_pulse", 32'(err_conflict), 32'd1);
        check1("conflict_no_stall", 32'(mem_stall), 32'd0);
        step();
        access(1'b1, 1'b0, 32'h80, 32'd0, got);
        check1("conflict_array_kept", got, 32'h1111_2222);

        pulse_req(1'b1, 1'b0, 32'h42, 1);
        @(negedge clk);
        check1("misaligned_pulse", 32'(err_misaligned), 32'd1);
        check1("misaligned_rdata_held", mem_rdata, 32'h1111_2222);
        step();
        pulse_req(1'b1, 1'b1, 32'h83, 3);
        pulse_req(1'b0, 1'b1, 32'h41, 3);
        step();

        access(1'b0, 1'b1, 32'h10, 32'h0BAD_F00D, got);
        set_req(1'b0, 1'b1, 32'h10, 32'h1234_5678);
        step();
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        step();
        @(negedge clk);
        check1("reset_mid_done", 32'(mem_done), 32'd0);
        step();
        rst = 1'b1;
        step();
        access(1'b1, 1'b0, 32'h10, 32'd0, got);
        check1("reset_dropped_write", got, 32'h0BAD_F00D);

        access(1'b0, 1'b1, 32'h1000, 32'hA5A5_A5A5, got);
        access(1'b1, 1'b0, 32'h0000, 32'd0, got);
        check1("wrap_read", got, 32'hA5A5_A5A5);

        for (int c = 0; c < 2500; c++) begin
            r   = int'($urandom_range(0, 99));
            idx = int'($urandom_range(0, 15));
            a   = (32'($urandom_range(0, 3)) << 12) | (32'(idx) << 2);
            if (r < 25) begin
                set_req(1'b0, 1'b0, a, $urandom);
            end else if (r < 29) begin
                set_req(1'b1, 1'b1, a | 32'($urandom_range(0, 3)), $urandom);
            end else if (r < 34) begin
                set_req($urandom_range(0, 1) == 1, 1'b0, a | 32'($urandom_range(1, 3)), $urandom);
                wr = ~rd;
            end else begin
                set_req(1'b0, 1'b0, a, $urandom);
                if ($urandom_range(0, 1) == 1) rd = 1'b1;
                else                           wr = 1'b1;
            end
            rst = ($urandom_range(0, 299) != 0);
            step();
        end
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        failures++;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the 32-bit pipelined MIPS core.
- Accepts the pipeline's memread/memwrite requests, services them from an internal word array after a fixed number of wait states, and back-pressures the pipeline with mem_stall until each access completes.
- Flags illegal requests (read and write together, misaligned address) instead of servicing them.

Parameters:
- ADDR_W, 10, word-address bits; array depth is 2^ADDR_W words.
- WAIT_CYCLES, 2, stall cycles per access; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- mem_memread  in  1  load request from the MEM stage.
- mem_memwrite  in  1  store request from the MEM stage.
- mem_addr  in  32  byte address; bits [ADDR_W+1:2] index the array, upper bits ignored (wrap).
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data, registered.
- mem_stall  out  1  pipeline freeze request, combinational.
- mem_done  out  1  one-cycle pulse, access completed.
- err_conflict  out  1  one-cycle pulse, read and write both high.
- err_misaligned  out  1  one-cycle pulse, mem_addr[1:0] != 0 on a request.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, counter=0, mem_rdata=0, mem_done=0, err_* =0, mem_stall=0.
  - Array contents are not cleared.
  - Reset mid-access aborts it: a write not yet committed is dropped, and no mem_done is produced.
- States: IDLE, WAIT, RESP.
- Valid request: (mem_memread XOR mem_memwrite) and mem_addr[1:0]==0.
- IDLE:
  - On a valid request in cycle T: mem_stall=1 combinationally in T.
  - Latch op, address index and wdata; counter=WAIT_CYCLES-1.
  - Go to WAIT, or go directly to the commit edge when WAIT_CYCLES==1.
- WAIT:
  - mem_stall=1.
  - Counter decrements each cycle.
  - On the edge where counter==0 (end of cycle T+WAIT_CYCLES-1), the access commits and the state goes to RESP:
    - read: mem_rdata <= array[idx];
    - write: array[idx] <= wdata.
- RESP, cycle T+WAIT_CYCLES:
  - mem_stall=0, mem_done=1.
  - The pipeline still presents the completed request this cycle; it must be ignored, not re-accepted.
  - Next state IDLE.
- Latency summary:
  - exactly WAIT_CYCLES stalled cycles per access;
  - read data valid from cycle T+WAIT_CYCLES;
  - mem_rdata holds its value until the next committed read.
  - A write leaves mem_rdata unchanged.
- Illegal request in IDLE:
  - both read and write high: err_conflict=1 in the next cycle;
  - misaligned address: err_misaligned=1 in the next cycle;
  - both conditions together: only err_conflict fires.
  - No access, no stall, state stays IDLE.
  - A persistently held illegal request pulses its error every cycle.
- Inputs during WAIT/RESP are ignored; the latched copy is used.
- Back-to-back requests: a new request is only accepted in IDLE, so minimum spacing is WAIT_CYCLES+1 cycles per access.
- No request in IDLE: all outputs 0 except mem_rdata, which holds.

Test Plan:
- Reset (rst low 2 cycles), then idle 3 cycles -> mem_stall=0, mem_done=0, mem_rdata=0 throughout.
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x40 at T, then read 0x40 -> write: stall high T,T+1, mem_done at T+2. Read: stall 2 cycles, mem_rdata=0xDEADBEEF with mem_done 2 cycles after accept.
- Request held through RESP (pipeline-style, memread held high to T+2) -> exactly one mem_done; a second access begins only when the request is re-presented in IDLE.
- memread=memwrite=1 at 0x80 -> err_conflict pulses next cycle, no stall, array[0x20] unchanged (verified by a later read).
- Read from 0x42 -> err_misaligned pulses, no stall, mem_rdata unchanged.
- Write 0x12345678 to 0x10, rst driven low during WAIT before the commit edge; release and read 0x10 -> old value returned (write dropped), no mem_done during the reset.
- Wrap: write 0xA5A5A5A5 to 0x1000 with ADDR_W=10 -> a read of 0x0000 returns 0xA5A5A5A5.
